// File: rtl/vn_iblut_pkg.sv
// Shared types and default widths for the VN information-bottleneck LUT controllers.
package vn_iblut_pkg;

    localparam int unsigned DEF_WR_ADDR_BITWIDTH = 6;
    localparam int unsigned DEF_RD_ADDR_BITWIDTH = 6;
    localparam int unsigned DEF_WR_BITWIDTH      = 4;
    localparam int unsigned DEF_MSG_BITWIDTH     = 4;
    localparam int unsigned DEF_VN_LOAD_CYCLE    = 64;
    localparam int unsigned DEF_REQ_NUM          = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_SERVE = 2'd3
    } lut_state_e;

    // Index width for an n-entry selector; never collapses to zero bits.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vn_iblut_load_arb_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after the pointer, then
// moves the pointer just past the winner. Reusable by any shared-LUT controller.
module rr_arbiter
    import vn_iblut_pkg::*;
#(
    parameter int unsigned REQ_NUM = DEF_REQ_NUM
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [REQ_NUM-1:0] i_req,
    output logic [REQ_NUM-1:0] o_grant
);

    localparam int unsigned IDX_W = idx_w(REQ_NUM);

    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_nxt;
    logic             w_any;

    // Unrolled over every pointer value so all bit selects stay constant.
    always_comb begin
        o_grant = '0;
        w_any   = 1'b0;
        w_nxt   = r_ptr;
        for (int p = 0; p < REQ_NUM; p++) begin
            if (r_ptr == IDX_W'(p)) begin
                for (int i = 0; i < REQ_NUM; i++) begin
                    if (!w_any && i_req[(p + i) % REQ_NUM]) begin
                        w_any                       = 1'b1;
                        o_grant[(p + i) % REQ_NUM]  = 1'b1;
                        w_nxt                       = IDX_W'((p + i + 1) % REQ_NUM);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_any) begin
            r_ptr <= w_nxt;
        end
    end

endmodule

// File: rtl/vn_iblut_load_arb.sv
// Controller for one shared VN IB-LUT cell: streams a LUT image into the write
// port, then arbitrates round-robin read lookups from the sharing VNUs.
module vn_iblut_load_arb
    import vn_iblut_pkg::*;
#(
    parameter int unsigned WR_ADDR_BITWIDTH = DEF_WR_ADDR_BITWIDTH,
    parameter int unsigned RD_ADDR_BITWIDTH = DEF_RD_ADDR_BITWIDTH,
    parameter int unsigned WR_BITWIDTH      = DEF_WR_BITWIDTH,
    parameter int unsigned MSG_BITWIDTH     = DEF_MSG_BITWIDTH,
    parameter int unsigned VN_LOAD_CYCLE    = DEF_VN_LOAD_CYCLE,
    parameter int unsigned REQ_NUM          = DEF_REQ_NUM
) (
    input  logic                                sys_clk,
    input  logic                                rst,
    input  logic                                load_start_i,
    input  logic                                ld_valid_i,
    input  logic [WR_BITWIDTH-1:0]              ld_data_i,
    output logic                                ld_ready_o,
    output logic                                load_done_o,
    output logic                                serve_o,
    output logic [WR_ADDR_BITWIDTH-1:0]         lut_waddr_o,
    output logic [WR_BITWIDTH-1:0]              lut_wdata_o,
    output logic                                lut_wen_o,
    output logic [RD_ADDR_BITWIDTH-1:0]         lut_raddr_o,
    input  logic [MSG_BITWIDTH-1:0]             lut_msg_i,
    input  logic [REQ_NUM-1:0]                  req_valid_i,
    input  logic [REQ_NUM*RD_ADDR_BITWIDTH-1:0] req_addr_i,
    output logic [REQ_NUM-1:0]                  req_grant_o,
    output logic [REQ_NUM-1:0]                  rsp_valid_o,
    output logic [MSG_BITWIDTH-1:0]             rsp_msg_o
);

    lut_state_e                  r_state;
    logic [WR_ADDR_BITWIDTH-1:0] r_cnt;
    logic                        r_ld_ready;
    logic                        r_load_done;
    logic                        r_serve;
    logic [REQ_NUM-1:0]          r_rsp_vld;
    logic [RD_ADDR_BITWIDTH-1:0] r_raddr;

    logic                        w_wr;
    logic                        w_last;
    logic [REQ_NUM-1:0]          w_req;
    logic [REQ_NUM-1:0]          w_grant;
    logic [RD_ADDR_BITWIDTH-1:0] w_gaddr;

    // Reset suppresses the write strobe and the grants in its own cycle.
    assign w_wr   = !rst && (r_state == ST_LOAD) && ld_valid_i;
    assign w_last = (r_cnt == WR_ADDR_BITWIDTH'(VN_LOAD_CYCLE - 1));
    assign w_req  = (!rst && (r_state == ST_SERVE)) ? req_valid_i : '0;

    rr_arbiter #(
        .REQ_NUM (REQ_NUM)
    ) u_rr_arbiter (
        .clk     (sys_clk),
        .rst     (rst),
        .i_req   (w_req),
        .o_grant (w_grant)
    );

    // Read address follows the winner; with no grant it holds the last one.
    always_comb begin
        w_gaddr = r_raddr;
        for (int k = 0; k < REQ_NUM; k++) begin
            if (w_grant[k]) begin
                w_gaddr = req_addr_i[k*RD_ADDR_BITWIDTH +: RD_ADDR_BITWIDTH];
            end
        end
    end

    assign lut_wen_o   = !w_wr;
    assign lut_waddr_o = r_cnt;
    assign lut_wdata_o = w_wr ? ld_data_i : '0;
    assign lut_raddr_o = w_gaddr;
    assign req_grant_o = w_grant;

    assign ld_ready_o  = r_ld_ready;
    assign load_done_o = r_load_done;
    assign serve_o     = r_serve;
    assign rsp_valid_o = r_rsp_vld;
    // The LUT read is synchronous, so its data lines up with the registered valid.
    assign rsp_msg_o   = (|r_rsp_vld) ? lut_msg_i : '0;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_ld_ready  <= 1'b0;
            r_load_done <= 1'b0;
            r_serve     <= 1'b0;
            r_rsp_vld   <= '0;
            r_raddr     <= '0;
        end else begin
            r_load_done <= 1'b0;
            r_rsp_vld   <= w_grant;
            r_raddr     <= w_gaddr;
            case (r_state)
                ST_IDLE: begin
                    if (load_start_i) begin
                        r_state    <= ST_LOAD;
                        r_cnt      <= '0;
                        r_ld_ready <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (ld_valid_i) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_last) begin
                            r_state     <= ST_SERVE;
                            r_ld_ready  <= 1'b0;
                            r_load_done <= 1'b1;
                            r_serve     <= 1'b1;
                        end
                    end
                end
                ST_SERVE: begin
                    if (load_start_i) begin
                        r_state <= ST_DRAIN;
                        r_serve <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    // The response granted in the last SERVE cycle retires here.
                    r_state    <= ST_LOAD;
                    r_cnt      <= '0;
                    r_ld_ready <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vn_iblut_load_arb.sv
// Directed bench for vn_iblut_load_arb with a behavioural LUT cell and a response scoreboard.
module tb_vn_iblut_load_arb;

    localparam int AW = 6;
    localparam int DW = 4;
    localparam int N  = 2;
    localparam int LC = 64;

    logic            sys_clk = 1'b0;
    logic            rst = 1'b1;
    logic            load_start_i = 1'b0;
    logic            ld_valid_i = 1'b0;
    logic [DW-1:0]   ld_data_i = '0;
    logic            ld_ready_o;
    logic            load_done_o;
    logic            serve_o;
    logic [AW-1:0]   lut_waddr_o;
    logic [DW-1:0]   lut_wdata_o;
    logic            lut_wen_o;
    logic [AW-1:0]   lut_raddr_o;
    logic [DW-1:0]   lut_msg_i;
    logic [N-1:0]    req_valid_i = '0;
    logic [N*AW-1:0] req_addr_i = '0;
    logic [N-1:0]    req_grant_o;
    logic [N-1:0]    rsp_valid_o;
    logic [DW-1:0]   rsp_msg_o;

    always #5 sys_clk = ~sys_clk;

    vn_iblut_load_arb #(
        .WR_ADDR_BITWIDTH (AW),
        .RD_ADDR_BITWIDTH (AW),
        .WR_BITWIDTH      (DW),
        .MSG_BITWIDTH     (DW),
        .VN_LOAD_CYCLE    (LC),
        .REQ_NUM          (N)
    ) dut (
        .sys_clk      (sys_clk),
        .rst          (rst),
        .load_start_i (load_start_i),
        .ld_valid_i   (ld_valid_i),
        .ld_data_i    (ld_data_i),
        .ld_ready_o   (ld_ready_o),
        .load_done_o  (load_done_o),
        .serve_o      (serve_o),
        .lut_waddr_o  (lut_waddr_o),
        .lut_wdata_o  (lut_wdata_o),
        .lut_wen_o    (lut_wen_o),
        .lut_raddr_o  (lut_raddr_o),
        .lut_msg_i    (lut_msg_i),
        .req_valid_i  (req_valid_i),
        .req_addr_i   (req_addr_i),
        .req_grant_o  (req_grant_o),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_msg_o    (rsp_msg_o)
    );

    // Behavioural LUT cell: active-low write, synchronous read.
    logic [DW-1:0] lut_mem [0:LC-1];
    always @(posedge sys_clk) begin
        if (!lut_wen_o) lut_mem[lut_waddr_o] <= lut_wdata_o;
        lut_msg_i <= lut_mem[lut_raddr_o];
    end

    typedef struct packed {
        logic [N-1:0]  vld;
        logic [DW-1:0] msg;
    } rsp_t;

    rsp_t          sb[$];
    logic [DW-1:0] exp_img [0:LC-1];
    int            total = 0;
    int            bad = 0;
    logic          m_serve = 1'b0;
    int            m_ptr = 0;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] img(input int gen, input int a);
        case (gen)
            0:       return DW'(a);
            1:       return DW'(a * 3 + 7);
            default: return DW'((a >> 2) ^ 5);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, check the grant, and queue the response it implies.
    task automatic drive(input logic ls, input logic lv, input logic [DW-1:0] ld,
                         input logic [N-1:0] rv, input logic r);
        rsp_t          e;
        logic [N-1:0]  eg;
        logic [AW-1:0] ad;
        int            k;
        load_start_i = ls;
        ld_valid_i   = lv;
        ld_data_i    = ld;
        req_valid_i  = rv;
        rst          = r;
        #1;
        eg = '0;
        e  = '0;
        k  = -1;
        if (m_serve && !r) begin
            for (int i = 0; i < N; i++) begin
                if (k < 0 && rv[(m_ptr + i) % N]) k = (m_ptr + i) % N;
            end
        end
        if (k >= 0) eg[k] = 1'b1;
        chk("grant", 32'(req_grant_o), 32'(eg));
        if (k >= 0) begin
            ad = req_addr_i[k*AW +: AW];
            chk("raddr", 32'(lut_raddr_o), 32'(ad));
            e.vld = eg;
            e.msg = exp_img[ad];
            m_ptr = (k + 1) % N;
        end
        sb.push_back(e);
    endtask

    task automatic adv();
        rsp_t e;
        @(posedge sys_clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("rsp_valid", 32'(rsp_valid_o), 32'(e.vld));
            if (e.vld != 0) chk("rsp_msg", 32'(rsp_msg_o), 32'(e.msg));
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_ld_ready", 32'(ld_ready_o), 0);
        chk("rst_load_done", 32'(load_done_o), 0);
        chk("rst_serve", 32'(serve_o), 0);
        chk("rst_wen", 32'(lut_wen_o), 1);
        chk("rst_waddr", 32'(lut_waddr_o), 0);
        chk("rst_wdata", 32'(lut_wdata_o), 0);
        chk("rst_raddr", 32'(lut_raddr_o), 0);
        chk("rst_grant", 32'(req_grant_o), 0);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 0);
        chk("rst_rsp_msg", 32'(rsp_msg_o), 0);
    endtask

    task automatic start_idle();
        drive(1'b1, 1'b0, '0, req_valid_i, 1'b0);
        chk("idle_wen", 32'(lut_wen_o), 1);
        adv();
        chk("entry_ld_ready", 32'(ld_ready_o), 1);
        chk("entry_serve", 32'(serve_o), 0);
    endtask

    // load_start_i in SERVE: the grant of that cycle is answered during DRAIN.
    task automatic start_serve();
        drive(1'b1, 1'b0, '0, req_valid_i, 1'b0);
        adv();
        m_serve = 1'b0;
        chk("drain_serve", 32'(serve_o), 0);
        chk("drain_ld_ready", 32'(ld_ready_o), 0);
        drive(1'b1, 1'b1, 4'hA, req_valid_i, 1'b0);
        chk("drain_wen", 32'(lut_wen_o), 1);
        adv();
        chk("reload_ld_ready", 32'(ld_ready_o), 1);
    endtask

    task automatic load_body(input int gen, input int stall_every, input int abort_at);
        int            w;
        int            cyc;
        logic          lv;
        logic          r;
        logic [DW-1:0] d;
        w   = 0;
        cyc = 0;
        while (w < LC && cyc < 400) begin
            lv = !(stall_every > 0 && (cyc % stall_every) == stall_every - 1);
            r  = (abort_at >= 0 && w == abort_at);
            d  = img(gen, w);
            drive(cyc == 10, lv, d, req_valid_i, r);
            chk("ld_ready", 32'(ld_ready_o), 1);
            chk("wen", 32'(lut_wen_o), 32'(!(lv && !r)));
            if (lv && !r) begin
                chk("waddr", 32'(lut_waddr_o), w);
                chk("wdata", 32'(lut_wdata_o), 32'(d));
                exp_img[w] = d;
            end
            adv();
            cyc++;
            if (r) return;
            if (lv) w++;
            chk("load_done", 32'(load_done_o), 32'(w == LC));
            chk("serve", 32'(serve_o), 32'(w == LC));
        end
        if (w < LC) chk("load_bound", w, LC);
        m_serve = 1'b1;
    endtask

    task automatic serve_n(input int n, input logic [N-1:0] rv);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b0, '0, rv, 1'b0);
            adv();
            chk("serve_hold", 32'(serve_o), 1);
        end
    endtask

    initial begin
        req_addr_i = {6'd9, 6'd5};
        drive(1'b0, 1'b0, '0, 2'b11, 1'b1);
        adv();
        drive(1'b0, 1'b0, '0, 2'b11, 1'b1);
        adv();
        chk_reset_vals();
        m_ptr = 0;
        drive(1'b0, 1'b1, 4'h3, 2'b11, 1'b0);
        chk("idle_no_write", 32'(lut_wen_o), 1);
        adv();

        // Back-to-back image, data = addr[3:0].
        start_idle();
        load_body(0, 0, -1);

        // Two requesters, alternating grants.
        serve_n(6, 2'b11);
        // Requester 1 alone with pointer at 1.
        serve_n(1, 2'b01);
        req_addr_i = {6'd33, 6'd5};
        serve_n(5, 2'b10);
        // Pointer hold across idle cycles.
        serve_n(1, 2'b01);
        serve_n(2, 2'b00);
        serve_n(3, 2'b11);

        // Reload mid-traffic with a stalling stream.
        req_addr_i = {6'd9, 6'd5};
        start_serve();
        load_body(1, 3, -1);
        serve_n(4, 2'b11);

        // Reset during the load at word 30.
        start_serve();
        load_body(2, 0, 30);
        m_serve = 1'b0;
        m_ptr   = 0;
        chk_reset_vals();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 4'h7, 2'b11, 1'b0);
            chk("post_abort_wen", 32'(lut_wen_o), 1);
            adv();
            chk("post_abort_done", 32'(load_done_o), 0);
        end
        start_idle();
        load_body(2, 0, -1);
        req_addr_i = {6'd63, 6'd0};
        serve_n(4, 2'b11);
        req_addr_i = {6'd20, 6'd41};
        serve_n(3, 2'b11);

        // Reset while requests are pending: no response may follow.
        drive(1'b0, 1'b0, '0, 2'b11, 1'b1);
        adv();
        m_serve = 1'b0;
        m_ptr   = 0;
        chk_reset_vals();
        drive(1'b0, 1'b0, '0, 2'b11, 1'b0);
        adv();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
